// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline MEM/WB slice.
package mips_pipe_pkg;

    localparam int unsigned REG_W           = 5;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic {
        IDLE,
        WAIT
    } memState_t;

endpackage

// File: rtl/mips_mem_wb_reg.sv
// MEM/WB pipeline register: latches a retiring instruction, or inserts a bubble while MEM stalls.
module mips_mem_wb_reg
    import mips_pipe_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              retire,
    input  logic              regWriteIn,
    input  logic              memtoregIn,
    input  logic [REG_W-1:0]  writeRegIn,
    input  logic [DATA_W-1:0] writeDataIn,
    input  logic              busErrIn,
    input  logic              alignErrIn,
    output logic              RegWriteWB,
    output logic              MemtoregWB,
    output logic [REG_W-1:0]  WriteRegWB,
    output logic [DATA_W-1:0] WriteDataWB,
    output logic              BusErrWB,
    output logic              AlignErrWB
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            RegWriteWB  <= 1'b0;
            MemtoregWB  <= 1'b0;
            WriteRegWB  <= '0;
            WriteDataWB <= '0;
            BusErrWB    <= 1'b0;
            AlignErrWB  <= 1'b0;
        end else if (retire) begin
            RegWriteWB  <= regWriteIn;
            MemtoregWB  <= memtoregIn;
            WriteRegWB  <= writeRegIn;
            WriteDataWB <= writeDataIn;
            BusErrWB    <= busErrIn;
            AlignErrWB  <= alignErrIn;
        end else begin
            // Bubble: control and error flags clear, data and register number hold.
            RegWriteWB  <= 1'b0;
            MemtoregWB  <= 1'b0;
            BusErrWB    <= 1'b0;
            AlignErrWB  <= 1'b0;
        end
    end

endmodule

// File: rtl/mips_mem_wb_stage.sv
// MEM-stage data-memory controller (req/ready with timeout) feeding the MEM/WB register.
module mips_mem_wb_stage
    import mips_pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              MemReadMEM,
    input  logic              MemwriteMEM,
    input  logic              MemtoregMEM,
    input  logic              RegWriteMEM,
    input  logic [DATA_W-1:0] ALUResultMEM,
    input  logic [DATA_W-1:0] ReadData2MEM,
    input  logic [REG_W-1:0]  WriteRegMEM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              StallMEM,
    output logic              RegWriteWB,
    output logic              MemtoregWB,
    output logic [REG_W-1:0]  WriteRegWB,
    output logic [DATA_W-1:0] WriteDataWB,
    output logic              BusErrWB,
    output logic              AlignErrWB
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    memState_t         state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic              memOp, misaligned, access, abort, done, retire;
    logic              regWriteIn;
    logic [DATA_W-1:0] writeDataIn;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // The request cycle in IDLE counts as the first waited cycle, so abort
    // fires in the request cycle numbered TIMEOUT (WAIT with cnt == TIMEOUT-1).
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        dmem_req  = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                dmem_req = access;
                if (access && !dmem_ready) begin
                    stateNext = WAIT;
                    cntNext   = CNT_W'(1);
                end
            end
            WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else if (cnt == CNT_LAST) begin
                    abort     = 1'b1;
                    stateNext = IDLE;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
        if (RST) begin
            dmem_req = 1'b0;
            abort    = 1'b0;
        end
    end

    always_comb begin
        memOp      = MemReadMEM | MemwriteMEM;
        misaligned = memOp & (ALUResultMEM[1:0] != 2'b00);
        access     = memOp & ~misaligned;
        done       = dmem_req & dmem_ready;
        StallMEM   = dmem_req & ~dmem_ready & ~abort;
        retire     = ~StallMEM;

        dmem_we    = MemwriteMEM;
        dmem_addr  = ALUResultMEM;
        dmem_wdata = ReadData2MEM;

        regWriteIn  = RegWriteMEM & ~MemwriteMEM & ~misaligned & ~abort;
        writeDataIn = (MemtoregMEM && done) ? dmem_rdata : ALUResultMEM;
    end

    mips_mem_wb_reg u_memWbReg (
        .CLK         (CLK),
        .RST         (RST),
        .retire      (retire),
        .regWriteIn  (regWriteIn),
        .memtoregIn  (MemtoregMEM),
        .writeRegIn  (WriteRegMEM),
        .writeDataIn (writeDataIn),
        .busErrIn    (abort),
        .alignErrIn  (misaligned),
        .RegWriteWB  (RegWriteWB),
        .MemtoregWB  (MemtoregWB),
        .WriteRegWB  (WriteRegWB),
        .WriteDataWB (WriteDataWB),
        .BusErrWB    (BusErrWB),
        .AlignErrWB  (AlignErrWB)
    );

endmodule

// File: tb/tb_mips_mem_wb_stage.sv
// Bench for mips_mem_wb_stage: directed cases plus random instructions against an outcome model.
module tb_mips_mem_wb_stage;

    localparam int unsigned TO = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MemReadMEM, MemwriteMEM, MemtoregMEM, RegWriteMEM;
    logic [31:0] ALUResultMEM, ReadData2MEM;
    logic [4:0]  WriteRegMEM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ready;
    logic        StallMEM;
    logic        RegWriteWB, MemtoregWB;
    logic [4:0]  WriteRegWB;
    logic [31:0] WriteDataWB;
    logic        BusErrWB, AlignErrWB;

    int total = 0;
    int bad   = 0;

    mips_mem_wb_stage #(.TIMEOUT(TO)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .MemReadMEM   (MemReadMEM),
        .MemwriteMEM  (MemwriteMEM),
        .MemtoregMEM  (MemtoregMEM),
        .RegWriteMEM  (RegWriteMEM),
        .ALUResultMEM (ALUResultMEM),
        .ReadData2MEM (ReadData2MEM),
        .WriteRegMEM  (WriteRegMEM),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ready   (dmem_ready),
        .StallMEM     (StallMEM),
        .RegWriteWB   (RegWriteWB),
        .MemtoregWB   (MemtoregWB),
        .WriteRegWB   (WriteRegWB),
        .WriteDataWB  (WriteDataWB),
        .BusErrWB     (BusErrWB),
        .AlignErrWB   (AlignErrWB)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_wb_zero(input string tag);
        chk({tag, ".RegWriteWB"},  32'(RegWriteWB),  32'd0);
        chk({tag, ".MemtoregWB"},  32'(MemtoregWB),  32'd0);
        chk({tag, ".WriteRegWB"},  32'(WriteRegWB),  32'd0);
        chk({tag, ".WriteDataWB"}, WriteDataWB,      32'd0);
        chk({tag, ".BusErrWB"},    32'(BusErrWB),    32'd0);
        chk({tag, ".AlignErrWB"},  32'(AlignErrWB),  32'd0);
    endtask

    task automatic set_instr(input logic rd, input logic wr, input logic m2r, input logic rw,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wreg);
        MemReadMEM   = rd;
        MemwriteMEM  = wr;
        MemtoregMEM  = m2r;
        RegWriteMEM  = rw;
        ALUResultMEM = addr;
        ReadData2MEM = wd;
        WriteRegMEM  = wreg;
    endtask

    // lat = request cycle (1-based) in which memory answers; 0 = never answers.
    task automatic do_instr(input logic rd, input logic wr, input logic m2r, input logic rw,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wreg,
                            input int lat, input logic [31:0] rdv);
        logic        isAcc, mis, expAbort, expRw, retired;
        logic [31:0] expData;
        int          expStalls, stalls, cyc;
        mis      = (rd | wr) && (addr[1:0] != 2'b00);
        isAcc    = (rd | wr) && !mis;
        expAbort = isAcc && !(lat >= 1 && lat <= int'(TO));
        if (!isAcc)        expStalls = 0;
        else if (expAbort) expStalls = int'(TO) - 1;
        else               expStalls = lat - 1;
        expRw   = rw && !wr && !mis && !expAbort;
        expData = (m2r && isAcc && !expAbort) ? rdv : addr;

        set_instr(rd, wr, m2r, rw, addr, wd, wreg);
        stalls = 0;
        cyc    = 0;
        while (1) begin
            cyc++;
            // Non-access instructions see random spurious ready pulses, which must be ignored.
            dmem_ready = isAcc ? (cyc == lat) : 1'($urandom);
            dmem_rdata = (isAcc && cyc == lat) ? rdv : $urandom;
            @(negedge CLK);
            chk("dmem_req", 32'(dmem_req), 32'(isAcc));
            if (isAcc) begin
                chk("dmem_we",    32'(dmem_we), 32'(wr));
                chk("dmem_addr",  dmem_addr,    addr);
                chk("dmem_wdata", dmem_wdata,   wd);
            end
            if (cyc > 1) begin
                chk("bubble.RegWriteWB", 32'(RegWriteWB), 32'd0);
                chk("bubble.BusErrWB",   32'(BusErrWB),   32'd0);
            end
            retired = !StallMEM;
            if (StallMEM) stalls++;
            @(posedge CLK);
            #1;
            if (retired || cyc > int'(TO) + 2) break;
        end
        dmem_ready = 1'b0;
        chk("stall_cycles", 32'(stalls),     32'(expStalls));
        chk("RegWriteWB",   32'(RegWriteWB), 32'(expRw));
        chk("WriteRegWB",   32'(WriteRegWB), 32'(wreg));
        chk("BusErrWB",     32'(BusErrWB),   32'(expAbort));
        chk("AlignErrWB",   32'(AlignErrWB), 32'(mis));
        if (!mis && !expAbort) begin
            chk("WriteDataWB", WriteDataWB,      expData);
            chk("MemtoregWB",  32'(MemtoregWB), 32'(m2r));
        end
    endtask

    initial begin
        RST        = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        set_instr(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0, 5'd1);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("rst.dmem_req", 32'(dmem_req), 32'd0);
        chk("rst.StallMEM", 32'(StallMEM), 32'd0);
        @(posedge CLK);
        #1;
        check_wb_zero("rst");
        RST = 1'b0;

        // ALU op, aligned load with 3-cycle latency, zero-wait store, misaligned load
        do_instr(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 5'd5, 1, 32'h0);
        do_instr(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 5'd7, 3, 32'hDEAD_BEEF);
        do_instr(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h1234_5678, 5'd0, 1, 32'h0);
        do_instr(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0103, 32'h0, 5'd9, 1, 32'h0);
        // Timeout, then an ALU op must see dmem_req low
        do_instr(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0, 5'd3, 0, 32'h0);
        do_instr(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0044, 32'h0, 5'd4, 1, 32'h0);
        // Ready exactly in the last permitted cycle, and one cycle too late
        do_instr(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0, 5'd11, int'(TO), 32'hCAFE_F00D);
        do_instr(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0404, 32'h0, 5'd12, int'(TO) + 1, 32'h0BAD_0BAD);
        // Read and write both set: store, no register write
        do_instr(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0508, 32'hA5A5_5A5A, 5'd13, 2, 32'h0);

        // Reset while waiting
        set_instr(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0, 5'd6);
        dmem_ready = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        chk("rstwait.dmem_req", 32'(dmem_req), 32'd0);
        chk("rstwait.StallMEM", 32'(StallMEM), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check_wb_zero("rstwait");
        do_instr(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h0, 5'd8, 1, 32'h0);
        do_instr(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0, 5'd6, 2, 32'h7777_1234);

        for (int n = 0; n < 150; n++) begin
            int          kind, lat;
            logic [31:0] addr;
            logic        rd, wr, m2r, rw;
            kind = int'($urandom_range(0, 3));
            rd   = (kind == 1) || (kind == 3);
            wr   = (kind == 2) || (kind == 3);
            m2r  = (kind == 1);
            rw   = (kind == 1) ? 1'b1 : (kind == 0) ? 1'($urandom) : 1'($urandom_range(0, 3) == 0);
            addr = $urandom;
            if ($urandom_range(0, 5) != 0) addr[1:0] = 2'b00;
            lat  = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 4))
                                               : int'($urandom_range(0, TO + 3));
            do_instr(rd, wr, m2r, rw, addr, $urandom, 5'($urandom), lat, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
